// File: rtl/l2_wbuf_pkg.sv
// Shared types and default sizing for the L2 memory-side posted write buffer.
package l2_wbuf_pkg;

  localparam int unsigned DefDepth = 4;
  localparam int unsigned DefAddrW = 28;
  localparam int unsigned DefDataW = 128;

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StRdMiss,
    StResp
  } wbuf_state_e;

endpackage

// File: rtl/l2_wbuf_store.sv
// Circular entry store for the write buffer: FIFO pointers, newest-match read
// lookup and a coalesce lookup that never selects the in-flight head.
module l2_wbuf_store
  import l2_wbuf_pkg::*;
#(
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enq,
  input  logic [ADDR_W-1:0]          enq_addr,
  input  logic [DATA_W-1:0]          enq_data,
  input  logic                       upd,
  input  logic [$clog2(DEPTH)-1:0]   upd_idx,
  input  logic [DATA_W-1:0]          upd_data,
  input  logic                       pop,
  input  logic                       head_busy,
  input  logic [ADDR_W-1:0]          lookup_addr,
  output logic                       hit,
  output logic [DATA_W-1:0]          hit_data,
  output logic                       co_hit,
  output logic [$clog2(DEPTH)-1:0]   co_idx,
  output logic [ADDR_W-1:0]          head_addr,
  output logic [DATA_W-1:0]          head_data,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PtrW-1:0]   head_q, tail_q;
  logic [CntW-1:0]   count_q;
  logic [PtrW-1:0]   hit_idx, hit_scan, co_scan;

  // Scan oldest to newest so the last match wins: the newest copy of a line.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_scan = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      hit_scan = head_q + PtrW'(i);
      if (valid_q[hit_scan] && (addr_q[hit_scan] == lookup_addr)) begin
        hit     = 1'b1;
        hit_idx = hit_scan;
      end
    end
  end

  // Coalescing into the head while it drains would be lost: mem_wdata is already latched.
  always_comb begin
    co_hit  = 1'b0;
    co_idx  = '0;
    co_scan = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      co_scan = head_q + PtrW'(i);
      if (valid_q[co_scan] && (addr_q[co_scan] == lookup_addr) &&
          !(head_busy && (co_scan == head_q))) begin
        co_hit = 1'b1;
        co_idx = co_scan;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      count_q <= count_q + CntW'(enq) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q] <= enq_addr;
      data_q[tail_q] <= enq_data;
    end else if (upd) begin
      data_q[upd_idx] <= upd_data;
    end
  end

  assign hit_data  = data_q[hit_idx];
  assign head_addr = addr_q[head_q];
  assign head_data = data_q[head_q];
  assign empty     = (count_q == '0);
  assign full      = (count_q == CntW'(DEPTH));

endmodule

// File: rtl/l2_mem_write_buffer.sv
// Posted write buffer between an L2 memory port and slow memory: one-cycle writeback
// completion, background drain, read-miss priority and read forwarding from buffered lines.
module l2_mem_write_buffer
  import l2_wbuf_pkg::*;
#(
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              up_read,
  input  logic              up_write,
  input  logic [ADDR_W-1:0] up_addr,
  input  logic [DATA_W-1:0] up_wdata,
  output logic [DATA_W-1:0] up_rdata,
  output logic              up_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              buf_empty
);

  wbuf_state_e state_q, state_d;

  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] up_rdata_q, up_rdata_d;

  logic                     enq, upd, pop;
  logic                     hit, co_hit, empty, full;
  logic [DATA_W-1:0]        hit_data, head_data;
  logic [ADDR_W-1:0]        head_addr;
  logic [$clog2(DEPTH)-1:0] co_idx;

  l2_wbuf_store #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_store (
    .clk         (clk),
    .rst_n       (rst_n),
    .enq         (enq),
    .enq_addr    (up_addr),
    .enq_data    (up_wdata),
    .upd         (upd),
    .upd_idx     (co_idx),
    .upd_data    (up_wdata),
    .pop         (pop),
    .head_busy   (state_q == StDrain),
    .lookup_addr (up_addr),
    .hit         (hit),
    .hit_data    (hit_data),
    .co_hit      (co_hit),
    .co_idx      (co_idx),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .empty       (empty),
    .full        (full)
  );

  always_comb begin
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    up_rdata_d  = up_rdata_q;
    enq         = 1'b0;
    upd         = 1'b0;
    pop         = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Upstream requests beat draining; a write blocked by a full buffer lets the drain run.
        if (up_read) begin
          if (hit) begin
            up_rdata_d = hit_data;
            state_d    = StResp;
          end else begin
            mem_read_d = 1'b1;
            mem_addr_d = up_addr;
            state_d    = StRdMiss;
          end
        end else if (up_write && co_hit) begin
          upd     = 1'b1;
          state_d = StResp;
        end else if (up_write && !full) begin
          enq     = 1'b1;
          state_d = StResp;
        end else if (!empty) begin
          mem_write_d = 1'b1;
          mem_addr_d  = head_addr;
          mem_wdata_d = head_data;
          state_d     = StDrain;
        end
      end
      StDrain: begin
        if (mem_ready) begin
          pop         = 1'b1;
          mem_write_d = 1'b0;
          state_d     = StIdle;
        end
      end
      StRdMiss: begin
        if (mem_ready) begin
          mem_read_d = 1'b0;
          up_rdata_d = mem_rdata;
          state_d    = StResp;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      up_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      up_rdata_q  <= up_rdata_d;
    end
  end

  assign up_ready  = (state_q == StResp);
  assign up_rdata  = up_rdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign buf_empty = empty && (state_q != StDrain);

endmodule

// File: doc/l2_mem_write_buffer.md
# l2_mem_write_buffer

Posted write buffer between an L2 cache's memory-side port and a slow 128-bit memory. It lets dirty-line writebacks complete toward L2 in one cycle and drains them to memory in the background. It gives read misses priority over draining and forwards read data from buffered lines, so L2 never sees stale memory contents. There is one instance per L2, one for the I path and one for the D path, inserted in CHIP between each L2_Cache and its slow memory.

## Interface
- DEPTH, 4: buffered line entries, power of two, ≥2
- ADDR_W, 28: line address width (byte address [31:4])
- DATA_W, 128: line width
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- up_read  in  1  L2 line read request, held until up_ready
- up_write  in  1  L2 line writeback request, held until up_ready; never asserted together with up_read
- up_addr  in  ADDR_W  line address, stable while a request is held
- up_wdata  in  DATA_W  writeback data
- up_rdata  out  DATA_W  read data, valid in the up_ready cycle
- up_ready  out  1  one-cycle completion pulse
- mem_read  out  1  memory read, held until mem_ready
- mem_write  out  1  memory write, held until mem_ready
- mem_addr  out  ADDR_W  registered
- mem_wdata  out  DATA_W  registered
- mem_rdata  in  DATA_W  valid when mem_ready=1
- mem_ready  in  1  one-cycle memory completion
- buf_empty  out  1  no buffered entries and no drain in flight

## Operation
- The storage is a circular FIFO of DEPTH entries, each holding {valid, addr, data}, with head and tail pointers and a count (0..DEPTH).
- FSM states:
  - IDLE: accepts a new upstream request only when up_ready=0. This prevents double-processing of a request that is still held during its ready cycle.
  - DRAIN: mem_write is high for the head entry.
  - RD_MISS: mem_read is high.
  - RESP: up_ready pulse.
- Upstream write in IDLE:
  - If a non-in-flight entry has a matching addr, overwrite its data in place (coalesce). Count is unchanged.
  - Otherwise, if count<DEPTH, enqueue at tail, count+1.
  - Either way, go to RESP.
  - If count==DEPTH with no coalesce match, stay IDLE without accepting; retry each IDLE cycle.
- Upstream read in IDLE: search all valid entries, including the in-flight head.
  - Hit: return the newest matching entry (closest to tail) and go to RESP.
  - Miss: go to RD_MISS with mem_addr=up_addr.
- Drain start: in IDLE with count>0 and no acceptable upstream request this cycle, go to DRAIN with mem_addr/mem_wdata taken from head.
  - A full buffer with a pending write counts as "no acceptable request", so draining proceeds.
- DRAIN: on mem_ready, pop head (count−1) and return to IDLE.
  - The head entry is in flight; a write to the same addr appends a new entry rather than coalescing.
- RD_MISS: on mem_ready, capture mem_rdata into up_rdata and go to RESP.
- RESP: up_ready=1 for exactly one cycle, then IDLE.
- Reads are never issued while a drain is in flight. A read arriving during DRAIN waits for IDLE and then takes priority over the next drain.
- Write ordering to memory is strictly FIFO.

## Timing
- Reset values: all outputs 0 except buf_empty=1; count 0; pointers 0; FSM IDLE.
- A reset mid-transaction discards all buffered data and drops mem_read/mem_write immediately.
- Write accept: request sampled in IDLE at cycle t → up_ready at t+1.
- Read hit: request at t → up_ready and up_rdata at t+1.
- Read miss: request at t → mem_read high from t+1. mem_ready at cycle m → up_ready at m+1.
- Drain: decided at t → mem_write from t+1. mem_ready at m → head popped at the m edge, IDLE at m+1.
- mem_read and mem_write are never high together, and both deassert in the cycle after mem_ready.
- Count wraps are impossible: enqueue is blocked at count==DEPTH, and pointers wrap modulo DEPTH.

## Structure
- Package l2_wbuf_pkg holds the FSM state enum {IDLE, DRAIN, RD_MISS, RESP} and the default ADDR_W/DATA_W/DEPTH constants.
- Sub-module l2_wbuf_store holds the entry array, head/tail/count, newest-match search (hit, index, data), and the coalesce-match output that excludes the in-flight head.
- The top level holds the FSM and output registers.

## Test plan
- Reset during DRAIN (mem_write=1) → mem_write=0 asynchronously; buf_empty=1 after reset; no stale write is issued later.
- Write addr 0x0000010, data A, then read 0x0000010 while undrained → up_ready one cycle after the read; up_rdata=A; no mem_read issued.
- Four writes to 0x1–0x4 with memory latency 10 cycles, then a fifth write to 0x5 → fifth up_ready delayed until the 0x1 drain's mem_ready; memory sees writes in order 0x1..0x5.
- Write 0x7 data A, then 0x7 data B before drain starts → single mem_write of B; count stays 1.
- Read miss to 0x9 while a drain of 0x3 is in flight → mem_read for 0x9 starts only after the 0x3 mem_ready; it precedes the drain of the next entry; up_rdata equals the memory contents.
- Write 0x3 while head 0x3 is in flight → new entry appended; a later read of 0x3 returns the new data; memory ends with the new data.
